// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared types and constants for the instruction-fetch queue slice.
//   IF_BUS_W          width of one IF->ID entry {adef_ex, inst, pc}
//   INST_SIZE_WORD    bus transfer size code for a 32-bit fetch
//   RESET_PC_DEFAULT  default first fetch address after reset
//   iq_entry_t        packed layout of one queue entry
//   redir_sel_t       which redirect source wins this cycle
// ---------------------------------------------------------------------------
package if_pkg;

    localparam int          IF_BUS_W         = 65;
    localparam logic [1:0]  INST_SIZE_WORD   = 2'b10;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

    typedef struct packed {
        logic        adef_ex;
        logic [31:0] inst;
        logic [31:0] pc;
    } iq_entry_t;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_EX,
        REDIR_ERTN,
        REDIR_BR
    } redir_sel_t;

endpackage

// File: rtl/if_inst_queue.sv
// ---------------------------------------------------------------------------
// if_inst_queue
// Synchronous FIFO with clear.  Used both as the IF->ID instruction queue and
// as the in-order tag FIFO holding the PCs of outstanding bus fetches.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_push          write i_pushData at the tail (ignored when full)
//   i_pushData      entry to write
//   i_pop           drop the head entry (ignored when empty)
//   i_clear         empty the FIFO; wins over push and pop
//   o_head          current head entry
//   o_count         number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module if_inst_queue import if_pkg::*; #(
    parameter int WIDTH = IF_BUS_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_pushData,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rdPtr;
    logic [AW-1:0]    r_wrPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push && (r_count != FULL_COUNT);
    assign w_doPop  = i_pop && (r_count != '0);
    assign o_head   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    // Pointers wrap naturally because DEPTH is a power of two; clear only
    // rewinds the pointers, stale storage is unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_pushData;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_doPush) - (AW+1)'(w_doPop);
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// IF stage that decouples fetch from decode: issues word fetches on a
// req/addr_ok/data_ok bus with several in flight, buffers returned
// instructions in an IQ_DEPTH-entry queue, and handles redirects
// (ex > ertn > br) at any time by discarding stale in-flight responses.
// Optional feature macro: IF_ADEF_EN (misaligned fetch_pc raises adef_ex
// instead of issuing a bus request).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_ex_flush / i_ex_entry         exception redirect and target
//   i_ertn_flush / i_ertn_pc        ertn redirect and target
//   i_br_taken / i_br_target        branch redirect and target
//   i_ds_allow_in                   ID accepts the head entry
//   o_fs_to_ds_valid / _bus         head valid, {adef_ex, inst, pc}
//   o_inst_req/_wr/_size/_addr      instruction bus request side
//   i_inst_addr_ok                  request accepted
//   i_inst_data_ok / i_inst_rdata   in-order response
// ---------------------------------------------------------------------------
module if_fetch_queue import if_pkg::*; #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_ex_flush,
    input  logic [31:0]         i_ex_entry,
    input  logic                i_ertn_flush,
    input  logic [31:0]         i_ertn_pc,
    input  logic                i_br_taken,
    input  logic [31:0]         i_br_target,
    input  logic                i_ds_allow_in,
    output logic                o_fs_to_ds_valid,
    output logic [IF_BUS_W-1:0] o_fs_to_ds_bus,
    output logic                o_inst_req,
    output logic                o_inst_wr,
    output logic [1:0]          o_inst_size,
    output logic [31:0]         o_inst_addr,
    input  logic                i_inst_addr_ok,
    input  logic                i_inst_data_ok,
    input  logic [31:0]         i_inst_rdata
);

    localparam int          CW      = $clog2(IQ_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(IQ_DEPTH);

    logic [31:0]   r_fetchPc;
    logic [31:0]   r_pendAddr;
    logic          r_reqPending;
    logic          r_pendStale;
    logic [CW-1:0] r_discardCnt;

    redir_sel_t    w_redirSel;
    logic          w_redirect;
    logic [31:0]   w_redirTarget;
    logic [CW-1:0] w_iqCount;
    logic [CW-1:0] w_outstanding;
    logic [CW-1:0] w_outNext;
    logic [CW-1:0] w_discardNext;
    logic [31:0]   w_tagPc;
    logic          w_room;
    logic          w_adefBlock;
    logic          w_adefPush;
    logic          w_issue;
    logic          w_addrFire;
    logic          w_pendNext;
    logic          w_dataKeep;
    logic          w_iqPush;
    logic          w_iqPop;
    iq_entry_t     w_pushEntry;

    // Pick the highest-priority redirect source and its target.
    always_comb begin
        w_redirSel    = REDIR_NONE;
        w_redirTarget = '0;
        if (i_ex_flush) begin
            w_redirSel    = REDIR_EX;
            w_redirTarget = i_ex_entry;
        end else if (i_ertn_flush) begin
            w_redirSel    = REDIR_ERTN;
            w_redirTarget = i_ertn_pc;
        end else if (i_br_taken) begin
            w_redirSel    = REDIR_BR;
            w_redirTarget = i_br_target;
        end
        w_redirect = (w_redirSel != REDIR_NONE);
    end

    // Queue occupancy plus in-flight fetches may never exceed IQ_DEPTH, so
    // every returned instruction is guaranteed a slot.
    assign w_room = ({1'b0, w_iqCount} + {1'b0, w_outstanding}) < DEPTH_W;

`ifdef IF_ADEF_EN
    logic r_adefStop;

    // A misaligned fetch_pc never reaches the bus; once older fetches have
    // drained, a single adef entry is queued and fetch parks until redirect.
    assign w_adefBlock = (r_fetchPc[1:0] != 2'b00) || r_adefStop;
    assign w_adefPush  = (r_fetchPc[1:0] != 2'b00) && !r_adefStop && !r_reqPending
                         && (w_outstanding == '0) && (w_iqCount != CW'(IQ_DEPTH))
                         && !w_redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_adefStop <= 1'b0;
        end else if (w_redirect) begin
            r_adefStop <= 1'b0;
        end else if (w_adefPush) begin
            r_adefStop <= 1'b1;
        end
    end
`else
    assign w_adefBlock = 1'b0;
    assign w_adefPush  = 1'b0;
`endif

    // A request already raised stays up with its address until accepted;
    // if a redirect hit it meanwhile, the old address is replayed from
    // r_pendAddr while fetch_pc already holds the new target.
    assign w_issue     = !w_adefBlock && w_room;
    assign o_inst_req  = !reset && (r_reqPending || w_issue);
    assign o_inst_addr = reset ? 32'h0 : (r_pendStale ? r_pendAddr : r_fetchPc);
    assign o_inst_wr   = 1'b0;
    assign o_inst_size = INST_SIZE_WORD;
    assign w_addrFire  = o_inst_req && i_inst_addr_ok;
    assign w_pendNext  = o_inst_req && !i_inst_addr_ok;

    // Tag FIFO: its count is the number of outstanding fetches.
    if_inst_queue #(.WIDTH(32), .DEPTH(IQ_DEPTH)) u_tagFifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_addrFire),
        .i_pushData (o_inst_addr),
        .i_pop      (i_inst_data_ok),
        .i_clear    (1'b0),
        .o_head     (w_tagPc),
        .o_count    (w_outstanding)
    );

    // Responses arriving in a redirect cycle are stale regardless of count.
    assign w_dataKeep  = i_inst_data_ok && (r_discardCnt == '0);
    assign w_iqPush    = !w_redirect && (w_dataKeep || w_adefPush);
    assign w_iqPop     = o_fs_to_ds_valid && i_ds_allow_in && !w_redirect;
    assign w_pushEntry = w_adefPush ? '{adef_ex: 1'b1, inst: 32'h0, pc: r_fetchPc}
                                    : '{adef_ex: 1'b0, inst: i_inst_rdata, pc: w_tagPc};

    if_inst_queue #(.WIDTH(IF_BUS_W), .DEPTH(IQ_DEPTH)) u_instQueue (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_iqPush),
        .i_pushData (w_pushEntry),
        .i_pop      (w_iqPop),
        .i_clear    (w_redirect),
        .o_head     (o_fs_to_ds_bus),
        .o_count    (w_iqCount)
    );

    assign o_fs_to_ds_valid = (w_iqCount != '0);

    // On redirect everything still in flight after this cycle becomes stale,
    // including a raised-but-unaccepted request; earlier stale fetches are
    // part of that same count, so back-to-back redirects accumulate.
    assign w_outNext = w_outstanding + CW'(w_addrFire) - CW'(i_inst_data_ok);

    always_comb begin
        w_discardNext = r_discardCnt;
        if (w_redirect) begin
            w_discardNext = w_outNext + CW'(w_pendNext);
        end else if (i_inst_data_ok && (r_discardCnt != '0)) begin
            w_discardNext = r_discardCnt - 1'b1;
        end
    end

    // Fetch PC, pending-request tracking and discard counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetchPc    <= RESET_PC;
            r_pendAddr   <= '0;
            r_reqPending <= 1'b0;
            r_pendStale  <= 1'b0;
            r_discardCnt <= '0;
        end else begin
            r_reqPending <= w_pendNext;
            r_pendStale  <= w_pendNext && (w_redirect || r_pendStale);
            if (w_pendNext) begin
                r_pendAddr <= o_inst_addr;
            end
            r_discardCnt <= w_discardNext;
            if (w_redirect) begin
                r_fetchPc <= w_redirTarget;
            end else if (w_addrFire && !r_pendStale) begin
                r_fetchPc <= r_fetchPc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
// Self-checking bench for if_fetch_queue.  A bus model answers every accepted
// fetch one cycle later with memWord(addr); the stimulus pushes the entries
// it expects ID to see into a scoreboard and a monitor compares each popped
// head against it.  Honours IF_ADEF_EN when defined.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;
    import if_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                exFlush = 1'b0;
    logic [31:0]         exEntry = '0;
    logic                ertnFlush = 1'b0;
    logic [31:0]         ertnPc = '0;
    logic                brTaken = 1'b0;
    logic [31:0]         brTarget = '0;
    logic                dsAllowIn = 1'b0;
    logic                fsValid;
    logic [IF_BUS_W-1:0] fsBus;
    logic                instReq;
    logic                instWr;
    logic [1:0]          instSize;
    logic [31:0]         instAddr;
    logic                instAddrOk = 1'b1;
    logic                instDataOk = 1'b0;
    logic [31:0]         instRdata = '0;

    int                  testsRun = 0;
    int                  failures = 0;
    int                  popCount = 0;
    int                  fireCount = 0;
    int                  fireBase = 0;
    logic                respEn = 1'b1;
    logic                busFire;
    logic [31:0]         busFireAddr;
    logic [IF_BUS_W-1:0] monExp;
    logic [IF_BUS_W-1:0] sb[$];
    logic [31:0]         busQ[$];

    always #5 clk = ~clk;

    if_fetch_queue dut (
        .clk              (clk),
        .reset            (reset),
        .i_ex_flush       (exFlush),
        .i_ex_entry       (exEntry),
        .i_ertn_flush     (ertnFlush),
        .i_ertn_pc        (ertnPc),
        .i_br_taken       (brTaken),
        .i_br_target      (brTarget),
        .i_ds_allow_in    (dsAllowIn),
        .o_fs_to_ds_valid (fsValid),
        .o_fs_to_ds_bus   (fsBus),
        .o_inst_req       (instReq),
        .o_inst_wr        (instWr),
        .o_inst_size      (instSize),
        .o_inst_addr      (instAddr),
        .i_inst_addr_ok   (instAddrOk),
        .i_inst_data_ok   (instDataOk),
        .i_inst_rdata     (instRdata)
    );

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'h5A5A_F00F;
    endfunction

    task automatic checkOutput(input string name, input logic [IF_BUS_W-1:0] actual,
                               input logic [IF_BUS_W-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectRun(input logic [31:0] pc, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back({1'b0, memWord(pc + 32'(4 * i)), pc + 32'(4 * i)});
        end
    endtask

    // One-cycle redirect; the DUT queue is emptied so the scoreboard is too.
    task automatic applyStimulus(input logic ex, input logic ertn, input logic br,
                                 input logic [31:0] exT, input logic [31:0] ertnT,
                                 input logic [31:0] brT);
        exFlush   = ex;
        ertnFlush = ertn;
        brTaken   = br;
        exEntry   = exT;
        ertnPc    = ertnT;
        brTarget  = brT;
        sb.delete();
        tick();
        exFlush   = 1'b0;
        ertnFlush = 1'b0;
        brTaken   = 1'b0;
    endtask

    // Let ID take exactly n entries, bounded in time.
    task automatic drain(input int n);
        int target;
        int waited;
        target    = popCount + n;
        waited    = 0;
        dsAllowIn = 1'b1;
        while (popCount < target && waited < 300) begin
            tick();
            waited++;
        end
        dsAllowIn = 1'b0;
        if (popCount < target) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL drain timeout: got %0d pops, expected %0d", popCount, target);
        end
    endtask

    // Bus model: accepted requests are answered in order one cycle later.
    always begin
        @(negedge clk);
        busFire = !reset && instReq && instAddrOk;
        busFireAddr = instAddr;
        if (busFire) begin
            fireCount++;
        end
        @(posedge clk);
        #1;
        if (busFire) begin
            busQ.push_back(busFireAddr);
        end
        if (respEn && busQ.size() > 0) begin
            instDataOk = 1'b1;
            instRdata  = memWord(busQ[0]);
            void'(busQ.pop_front());
        end else begin
            instDataOk = 1'b0;
        end
    end

    // Monitor: every head ID accepts is checked against the scoreboard.
    always begin
        @(negedge clk);
        if (!reset && fsValid && dsAllowIn && !(exFlush || ertnFlush || brTaken)) begin
            popCount++;
            if (sb.size() == 0) begin
                testsRun++;
                failures++;
                $display("[TB] FAIL extra entry: got %h, expected none", fsBus);
            end else begin
                monExp = sb.pop_front();
                checkOutput($sformatf("head entry pc %h", monExp[31:0]), fsBus, monExp);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset behaviour and first request.
        repeat (3) tick();
        checkOutput("reset inst_req", IF_BUS_W'(instReq), '0);
        checkOutput("reset valid", IF_BUS_W'(fsValid), '0);
        checkOutput("reset bus", fsBus, '0);
        checkOutput("reset inst_addr", IF_BUS_W'(instAddr), '0);
        checkOutput("inst_size", IF_BUS_W'(instSize), IF_BUS_W'(2'b10));
        checkOutput("inst_wr", IF_BUS_W'(instWr), '0);
        reset = 1'b0;
        #1;
        checkOutput("first inst_req", IF_BUS_W'(instReq), IF_BUS_W'(1'b1));
        checkOutput("first inst_addr", IF_BUS_W'(instAddr), IF_BUS_W'(32'h1C00_0000));

        // Streaming from reset PC.
        expectRun(32'h1C00_0000, 6);
        drain(6);

        // Backpressure: exactly four fetches fill the queue, then stall.
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 32'h1C00_0200);
        fireBase = fireCount;
        repeat (10) tick();
        checkOutput("full fires", IF_BUS_W'(fireCount - fireBase), IF_BUS_W'(4));
        checkOutput("full inst_req", IF_BUS_W'(instReq), '0);
        checkOutput("full valid", IF_BUS_W'(fsValid), IF_BUS_W'(1'b1));
        expectRun(32'h1C00_0200, 4);
        drain(4);

        // Two outstanding fetches dropped by a branch redirect.
        repeat (10) tick();
        respEn = 1'b0;
        expectRun(32'h1C00_0210, 2);
        drain(2);
        repeat (3) tick();
        checkOutput("capped inst_req", IF_BUS_W'(instReq), '0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 32'h1C00_0100);
        respEn = 1'b1;
        expectRun(32'h1C00_0100, 3);
        drain(3);

        // Pending request held across an exception redirect.
        repeat (10) tick();
        instAddrOk = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1C00_0400, '0, '0);
        repeat (2) tick();
        checkOutput("pending inst_req", IF_BUS_W'(instReq), IF_BUS_W'(1'b1));
        checkOutput("pending inst_addr", IF_BUS_W'(instAddr), IF_BUS_W'(32'h1C00_0400));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1C00_8000, '0, '0);
        checkOutput("held inst_req", IF_BUS_W'(instReq), IF_BUS_W'(1'b1));
        checkOutput("held inst_addr", IF_BUS_W'(instAddr), IF_BUS_W'(32'h1C00_0400));
        repeat (2) tick();
        checkOutput("still held inst_addr", IF_BUS_W'(instAddr), IF_BUS_W'(32'h1C00_0400));
        instAddrOk = 1'b1;
        expectRun(32'h1C00_8000, 2);
        drain(2);

        // Redirect priority: ex over ertn over br, then ertn over br.
        repeat (10) tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1C00_A000, 32'h1C00_B000, 32'h1C00_C000);
        expectRun(32'h1C00_A000, 2);
        drain(2);
        repeat (10) tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h1C00_A000, 32'h1C00_B000, 32'h1C00_C000);
        expectRun(32'h1C00_B000, 2);
        drain(2);

        // Misaligned branch target.
        repeat (10) tick();
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, 32'h1C00_0102);
`ifdef IF_ADEF_EN
        fireBase = fireCount;
        repeat (8) tick();
        checkOutput("adef fires", IF_BUS_W'(fireCount - fireBase), '0);
        sb.push_back({1'b1, 32'h0, 32'h1C00_0102});
        drain(1);
        repeat (5) tick();
        checkOutput("adef parked valid", IF_BUS_W'(fsValid), '0);
        checkOutput("adef parked inst_req", IF_BUS_W'(instReq), '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1C00_8000, '0, '0);
        expectRun(32'h1C00_8000, 2);
        drain(2);
`else
        expectRun(32'h1C00_0102, 2);
        drain(2);
`endif

        repeat (5) tick();
        checkOutput("scoreboard empty", IF_BUS_W'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
